// File: rtl/pc_update_unit.sv
// Program-counter stage: holds PC/EPC, applies unconditional or branch-conditional writes,
// and runs the exception vector-fetch sequence (save EPC, read handler byte, load PC).
module pc_update_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC_BASE = 32'd253,
    parameter int unsigned MEM_LAT      = 1,
    parameter logic [31:0] PC_INC       = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_next_in_i,
    input  logic        pc_write_i,
    input  logic        pc_write_cond_i,
    input  logic [1:0]  branch_op_i,
    input  logic        alu_zero_i,
    input  logic        alu_neg_i,
    input  logic        exc_req_i,
    input  logic [1:0]  exc_cause_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] pc_out_o,
    output logic [31:0] epc_out_o,
    output logic        exc_busy_o,
    output logic        exc_done_o
);

    typedef enum logic [1:0] {StIdle, StRd, StWait, StLoad} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] cnt_q, cnt_d;
    logic        take;

    always_comb begin
        case (branch_op_i)
            2'b00:   take = alu_zero_i;
            2'b01:   take = ~alu_zero_i;
            2'b10:   take = alu_zero_i | alu_neg_i;
            default: take = ~alu_zero_i & ~alu_neg_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                // Exception takes priority over any PC write in the same cycle.
                if (exc_req_i && (exc_cause_i != 2'b00)) begin
                    epc_d   = pc_q - PC_INC;
                    cause_d = exc_cause_i;
                    state_d = StRd;
                end else if (pc_write_i || (pc_write_cond_i && take)) begin
                    pc_d = pc_next_in_i;
                end
            end
            StRd: begin
                if (MEM_LAT > 1) begin
                    cnt_d   = MEM_LAT - 32'd2;
                    state_d = StWait;
                end else begin
                    state_d = StLoad;
                end
            end
            StWait: begin
                if (cnt_q == 32'd0) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StLoad: begin
                pc_d    = {24'b0, mem_rdata_i};
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            cause_q <= 2'b00;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // All strobes decode from the state register only, so exc_req never reaches mem_rd directly.
    always_comb begin
        mem_rd_o   = (state_q == StRd);
        mem_addr_o = 32'd0;
        if (state_q == StRd) begin
            mem_addr_o = EXC_VEC_BASE + {30'b0, cause_q} - 32'd1;
        end
        exc_busy_o = (state_q != StIdle);
        exc_done_o = (state_q == StLoad);
        pc_out_o   = pc_q;
        epc_out_o  = epc_q;
    end

    mem_rd_implies_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rd_o |-> exc_busy_o);
    done_returns_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        exc_done_o |=> !exc_busy_o);

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: vector table for PC writes, hand sequences for the exception flow
// (MEM_LAT=1 and MEM_LAT=3 instances), then randomized traffic against a cycle-level model.
module tb_pc_update_unit;

    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pc_write, pc_cond, zero, neg, exc_req;
    logic [31:0] pc_next;
    logic [1:0]  bop, cause;
    logic [7:0]  rdata;
    logic        mem_rd, busy, done;
    logic [31:0] mem_addr, pc, epc;

    logic        rst3_n, pc_write3, pc_cond3, zero3, neg3, exc_req3;
    logic [31:0] pc_next3;
    logic [1:0]  bop3, cause3;
    logic [7:0]  rdata3;
    logic        mem_rd3, busy3, done3;
    logic [31:0] mem_addr3, pc3, epc3;

    int checks   = 0;
    int failures = 0;

    pc_update_unit #(.MEM_LAT(LAT1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_next_in_i(pc_next), .pc_write_i(pc_write),
        .pc_write_cond_i(pc_cond), .branch_op_i(bop), .alu_zero_i(zero), .alu_neg_i(neg),
        .exc_req_i(exc_req), .exc_cause_i(cause), .mem_rdata_i(rdata), .mem_rd_o(mem_rd),
        .mem_addr_o(mem_addr), .pc_out_o(pc), .epc_out_o(epc), .exc_busy_o(busy),
        .exc_done_o(done)
    );

    pc_update_unit #(.MEM_LAT(LAT3)) dut3 (
        .clk_i(clk), .rst_ni(rst3_n), .pc_next_in_i(pc_next3), .pc_write_i(pc_write3),
        .pc_write_cond_i(pc_cond3), .branch_op_i(bop3), .alu_zero_i(zero3), .alu_neg_i(neg3),
        .exc_req_i(exc_req3), .exc_cause_i(cause3), .mem_rdata_i(rdata3), .mem_rd_o(mem_rd3),
        .mem_addr_o(mem_addr3), .pc_out_o(pc3), .epc_out_o(epc3), .exc_busy_o(busy3),
        .exc_done_o(done3)
    );

    function automatic logic [7:0] vec_byte(input logic [31:0] a);
        case (a)
            32'd253: vec_byte = 8'h3C;
            32'd254: vec_byte = 8'h80;
            32'd255: vec_byte = 8'hA4;
            default: vec_byte = 8'hEE;
        endcase
    endfunction

    // Memory responders: data is valid only in the cycle LAT cycles after the read strobe.
    int          wait1, wait3;
    logic [31:0] ra1, ra3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait1 <= -1; ra1 <= 32'd0; rdata <= 8'hEE;
        end else if (mem_rd) begin
            wait1 <= int'(LAT1) - 1; ra1 <= mem_addr;
            rdata <= (LAT1 == 1) ? vec_byte(mem_addr) : ~vec_byte(mem_addr);
        end else if (wait1 > 0) begin
            wait1 <= wait1 - 1;
            rdata <= (wait1 == 1) ? vec_byte(ra1) : ~vec_byte(ra1);
        end else begin
            wait1 <= -1; rdata <= ~vec_byte(ra1);
        end
    end
    always @(posedge clk or negedge rst3_n) begin
        if (!rst3_n) begin
            wait3 <= -1; ra3 <= 32'd0; rdata3 <= 8'hEE;
        end else if (mem_rd3) begin
            wait3 <= int'(LAT3) - 1; ra3 <= mem_addr3;
            rdata3 <= (LAT3 == 1) ? vec_byte(mem_addr3) : ~vec_byte(mem_addr3);
        end else if (wait3 > 0) begin
            wait3 <= wait3 - 1;
            rdata3 <= (wait3 == 1) ? vec_byte(ra3) : ~vec_byte(ra3);
        end else begin
            wait3 <= -1; rdata3 <= ~vec_byte(ra3);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        cond;
        logic [1:0]  op;
        logic        z;
        logic        n;
        logic [31:0] nxt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[11];

    // Reference model state for the random phase.
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    int          m_ph;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40,  32'h40};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h999, 32'h40};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h100, 32'h100};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h200, 32'h100};
        vecs[4]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h300, 32'h300};
        vecs[5]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h400, 32'h400};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h500, 32'h400};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h600, 32'h400};
        vecs[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h700, 32'h700};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h800, 32'h700};
        vecs[10] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 32'h24,  32'h24};

        rst_n = 1'b0; pc_write = 0; pc_cond = 0; bop = 0; zero = 0; neg = 0;
        exc_req = 0; cause = 0; pc_next = 0;
        rst3_n = 1'b0; pc_write3 = 0; pc_cond3 = 0; bop3 = 0; zero3 = 0; neg3 = 0;
        exc_req3 = 0; cause3 = 0; pc_next3 = 0;
        repeat (2) @(negedge clk);
        chk("rst pc", pc, 32'h0);
        chk("rst epc", epc, 32'h0);
        chk("rst busy", {31'b0, busy}, 32'h0);
        chk("rst mem_rd", {31'b0, mem_rd}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1; rst3_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            pc_write = vecs[i].wr; pc_cond = vecs[i].cond; bop = vecs[i].op;
            zero = vecs[i].z; neg = vecs[i].n; pc_next = vecs[i].nxt;
            @(negedge clk);
            chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
        end
        pc_write = 0; pc_cond = 0;

        // Overflow exception from pc=0x24 with single-cycle memory.
        exc_req = 1; cause = 2'b10;
        @(negedge clk);
        exc_req = 0;
        chk("ovf epc", epc, 32'h20);
        chk("ovf mem_rd", {31'b0, mem_rd}, 32'h1);
        chk("ovf mem_addr", mem_addr, 32'd254);
        chk("ovf busy", {31'b0, busy}, 32'h1);
        chk("ovf pc hold", pc, 32'h24);
        @(negedge clk);
        chk("ovf done", {31'b0, done}, 32'h1);
        chk("ovf mem_rd low", {31'b0, mem_rd}, 32'h0);
        chk("ovf addr zero", mem_addr, 32'h0);
        @(negedge clk);
        chk("ovf pc handler", pc, 32'h80);
        chk("ovf done low", {31'b0, done}, 32'h0);
        chk("ovf idle", {31'b0, busy}, 32'h0);

        // Exception beats a simultaneous write; held requests during busy are ignored.
        exc_req = 1; cause = 2'b11; pc_write = 1; pc_next = 32'h555;
        @(negedge clk);
        chk("dz pc not written", pc, 32'h80);
        chk("dz mem_addr", mem_addr, 32'd255);
        chk("dz epc", epc, 32'h7C);
        @(negedge clk);
        chk("dz done", {31'b0, done}, 32'h1);
        chk("dz epc held", epc, 32'h7C);
        chk("dz pc busy", pc, 32'h80);
        exc_req = 0; pc_write = 0;
        @(negedge clk);
        chk("dz pc handler", pc, 32'hA4);
        chk("dz idle", {31'b0, busy}, 32'h0);

        exc_req = 1; cause = 2'b01;
        @(negedge clk);
        exc_req = 0;
        chk("inv epc", epc, 32'hA0);
        chk("inv mem_addr", mem_addr, 32'd253);
        @(negedge clk);
        chk("inv done", {31'b0, done}, 32'h1);
        @(negedge clk);
        chk("inv pc handler", pc, 32'h3C);

        // Asynchronous reset while in RD aborts the sequence without a clock edge.
        exc_req = 1; cause = 2'b10;
        @(negedge clk);
        exc_req = 0;
        chk("abort in rd", {31'b0, mem_rd}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst pc", pc, 32'h0);
        chk("async rst epc", epc, 32'h0);
        chk("async rst busy", {31'b0, busy}, 32'h0);
        chk("async rst done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst pc", pc, 32'h0);
        chk("post rst busy", {31'b0, busy}, 32'h0);

        // MEM_LAT=3 instance: epc wraps from pc=0, one strobe cycle, data sampled 3 cycles on.
        exc_req3 = 1; cause3 = 2'b01;
        @(negedge clk);
        exc_req3 = 0;
        chk("l3 epc wrap", epc3, 32'hFFFF_FFFC);
        chk("l3 rd", {31'b0, mem_rd3}, 32'h1);
        chk("l3 addr", mem_addr3, 32'd253);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("l3 wait%0d rd", k), {31'b0, mem_rd3}, 32'h0);
            chk($sformatf("l3 wait%0d busy", k), {31'b0, busy3}, 32'h1);
            chk($sformatf("l3 wait%0d done", k), {31'b0, done3}, 32'h0);
        end
        @(negedge clk);
        chk("l3 load done", {31'b0, done3}, 32'h1);
        chk("l3 load rd", {31'b0, mem_rd3}, 32'h0);
        @(negedge clk);
        chk("l3 pc handler", pc3, 32'h3C);
        chk("l3 idle", {31'b0, busy3}, 32'h0);

        exc_req3 = 1; cause3 = 2'b10;
        @(negedge clk);
        exc_req3 = 0;
        @(negedge clk);
        chk("l3 in wait", {31'b0, busy3 & ~mem_rd3 & ~done3}, 32'h1);
        rst3_n = 1'b0;
        #1;
        chk("l3 rst pc", pc3, 32'h0);
        chk("l3 rst epc", epc3, 32'h0);
        chk("l3 rst busy", {31'b0, busy3}, 32'h0);
        repeat (2) @(negedge clk);
        rst3_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("l3 no done %0d", k), {31'b0, done3}, 32'h0);
            chk($sformatf("l3 pc stays %0d", k), pc3, 32'h0);
        end

        // Random traffic against a cycle-level model of the single-cycle-memory instance.
        m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00; m_ph = 0;
        for (int c = 0; c < 400; c++) begin
            logic        e_rd, e_busy, e_done, tk;
            logic [31:0] e_addr;
            e_rd   = (m_ph == 1);
            e_addr = e_rd ? (32'd253 + {30'b0, m_cause} - 32'd1) : 32'd0;
            e_busy = (m_ph != 0);
            e_done = (m_ph == 1 + int'(LAT1));
            checks++;
            if ({pc, epc, busy, done, mem_rd, mem_addr} !==
                {m_pc, m_epc, e_busy, e_done, e_rd, e_addr}) begin
                failures++;
                $display("FAIL rand cyc%0d: got pc=%h epc=%h b=%b d=%b rd=%b a=%h expected pc=%h epc=%h b=%b d=%b rd=%b a=%h",
                         c, pc, epc, busy, done, mem_rd, mem_addr,
                         m_pc, m_epc, e_busy, e_done, e_rd, e_addr);
            end
            pc_write = ($urandom_range(0, 3) == 0);
            pc_cond  = $urandom_range(0, 1) == 1;
            bop      = 2'($urandom_range(0, 3));
            zero     = $urandom_range(0, 1) == 1;
            neg      = $urandom_range(0, 1) == 1;
            pc_next  = $urandom;
            exc_req  = ($urandom_range(0, 5) == 0);
            cause    = 2'($urandom_range(0, 3));
            case (bop)
                2'b00:   tk = zero;
                2'b01:   tk = !zero;
                2'b10:   tk = zero || neg;
                default: tk = !zero && !neg;
            endcase
            if (m_ph == 0) begin
                if (exc_req && cause != 2'b00) begin
                    m_epc = m_pc - 32'd4; m_cause = cause; m_ph = 1;
                end else if (pc_write || (pc_cond && tk)) begin
                    m_pc = pc_next;
                end
            end else if (m_ph == 1 + int'(LAT1)) begin
                m_pc = {24'b0, vec_byte(32'd253 + {30'b0, m_cause} - 32'd1)};
                m_ph = 0;
            end else begin
                m_ph++;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
